// File: rtl/kb_pkg.sv
// kb_pkg: scan-code constants, FSM state encoding and byte helpers shared by the scan-code decoder.
package kb_pkg;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;

    // bit0 = E0 seen, bit1 = F0 seen
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    function automatic logic is_err_byte(input logic [7:0] b);
        return b == SC_ERR0 || b == SC_ERR1;
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return b == SC_EXT || b == SC_BRK;
    endfunction
endpackage

// File: rtl/scancode_dec_byte_capture.sv
// byte_capture: turns a level-held byte-ready into a one-cycle strobe aligned with the byte sample.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : byte-ready level from the receiver
//   data  : received byte, valid from the cycle after en rises
//   stb   : one-cycle strobe, high in the cycle after the rising edge of en
//   q     : byte to be sampled on the edge that ends the stb cycle
module byte_capture
    import kb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] data,
    output logic       stb,
    output logic [7:0] q
);
    logic en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
            stb  <= 1'b0;
        end else begin
            en_q <= en;
            stb  <= en & ~en_q;
        end
    end

    // The byte is only guaranteed one cycle after the rise, so it is consumed
    // directly on the edge ending the strobe cycle rather than re-registered.
    assign q = data;
endmodule

// File: rtl/scancode_dec.sv
// scancode_dec: decodes PS/2 set-2 scan-code bytes (E0/F0 prefixes) into key events with error/timeout flags.
//   clk         : system clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_byte_en   : byte-ready from receiver (level, one byte per rising edge)
//   i_byte      : received byte
//   o_key_valid : one-cycle key event pulse
//   o_key_code  : base scan code (held between events)
//   o_key_ext   : event was E0-prefixed (held)
//   o_key_break : event is a release (held)
//   o_err       : one-cycle protocol error / timeout pulse
//   o_mods      : {alt, ctrl, shift}; tracked only when KBD_MODIFIER_TRACK_EN is defined, else 0
module scancode_dec
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte,
    output logic       o_key_valid,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_break,
    output logic       o_err,
    output logic [2:0] o_mods
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             stb;
    logic [7:0]       data;
    logic             ext_f;
    logic             brk_f;
    logic             go_ext;
    logic             go_brk;
    logic             bad;
    logic             emit;
    logic             to_hit;

    byte_capture u_cap (
        .clk   (clk),
        .rst_n (i_rst_n),
        .en    (i_byte_en),
        .data  (i_byte),
        .stb   (stb),
        .q     (data)
    );

    // A prefix is legal only as E0, F0 or E0 F0; any other prefix repeat is an error.
    always_comb begin
        ext_f  = state == S_EXT || state == S_EXT_BRK;
        brk_f  = state == S_BRK || state == S_EXT_BRK;
        go_ext = state == S_IDLE && data == SC_EXT;
        go_brk = !brk_f && data == SC_BRK;
        bad    = is_err_byte(data) || (is_prefix(data) && !go_ext && !go_brk);
        emit   = !bad && !go_ext && !go_brk;
        nxt    = go_ext ? S_EXT : go_brk ? (ext_f ? S_EXT_BRK : S_BRK) : S_IDLE;
        to_hit = TIMEOUT_CYCLES != 0 && cnt == TO_LAST;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            o_key_valid <= 1'b0;
            o_key_code  <= '0;
            o_key_ext   <= 1'b0;
            o_key_break <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_key_valid <= 1'b0;
            o_err       <= 1'b0;
            if (stb) begin
                // an accepted byte always beats a simultaneous timeout
                cnt   <= '0;
                state <= nxt;
                o_err <= bad;
                if (emit) begin
                    o_key_valid <= 1'b1;
                    o_key_code  <= data;
                    o_key_ext   <= ext_f;
                    o_key_break <= brk_f;
                end
            end else if (state == S_IDLE) begin
                cnt <= '0;
            end else if (to_hit) begin
                cnt   <= '0;
                state <= S_IDLE;
                o_err <= 1'b1;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef KBD_MODIFIER_TRACK_EN
    logic shift;
    logic ctrl;
    logic alt;

    // E0 12 / E0 59 are fake shifts and must not disturb the shift state.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift <= 1'b0;
            ctrl  <= 1'b0;
            alt   <= 1'b0;
        end else if (stb && emit) begin
            if (!ext_f && (data == SC_LSHIFT || data == SC_RSHIFT)) shift <= !brk_f;
            if (data == SC_CTRL) ctrl <= !brk_f;
            if (data == SC_ALT) alt <= !brk_f;
        end
    end

    assign o_mods = {alt, ctrl, shift};
`else
    assign o_mods = 3'b000;
`endif
endmodule

// File: tb/tb_scancode_dec.sv
// tb_scancode_dec: scoreboard bench for scancode_dec with a prefix-list reference model and timing checks.
module tb_scancode_dec;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_byte_en = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       o_key_valid;
    logic [7:0] o_key_code;
    logic       o_key_ext;
    logic       o_key_break;
    logic       o_err;
    logic [2:0] o_mods;

    scancode_dec #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_byte_en   (i_byte_en),
        .i_byte      (i_byte),
        .o_key_valid (o_key_valid),
        .o_key_code  (o_key_code),
        .o_key_ext   (o_key_ext),
        .o_key_break (o_key_break),
        .o_err       (o_err),
        .o_mods      (o_mods)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        logic [2:0] mods;
        int         t;
    } exp_t;

    exp_t       q[$];
    logic [7:0] pend[$];
    logic [2:0] mods = 3'b000;
    int         total = 0;
    int         bad = 0;

    function automatic bit has(input logic [7:0] b);
        foreach (pend[i]) if (pend[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit legal_prefix(input logic [7:0] p[$]);
        if (p.size() == 1) return 1'b1;
        return p.size() == 2 && p[0] == 8'hE0 && p[1] == 8'hF0;
    endfunction

    function automatic void push_err(input int t);
        exp_t e;
        e = '{err: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0, mods: mods, t: t};
        q.push_back(e);
        pend.delete();
    endfunction

    function automatic void model(input logic [7:0] b, input int t);
        logic [7:0] cand[$];
        exp_t       e;
        bit         x;
        bit         k;
        if (b == 8'h00 || b == 8'hFF) begin
            push_err(t);
        end else if (b == 8'hE0 || b == 8'hF0) begin
            cand = pend;
            cand.push_back(b);
            if (legal_prefix(cand)) pend = cand;
            else push_err(t);
        end else begin
            x = has(8'hE0);
            k = has(8'hF0);
`ifdef KBD_MODIFIER_TRACK_EN
            if (!x && (b == 8'h12 || b == 8'h59)) mods[0] = !k;
            if (b == 8'h14) mods[1] = !k;
            if (b == 8'h11) mods[2] = !k;
`endif
            e = '{err: 1'b0, code: b, ext: x, brk: k, mods: mods, t: t};
            q.push_back(e);
            pend.delete();
        end
    endfunction

    // Call at a negedge; leaves at the negedge where the next byte may start.
    task automatic send(input logic [7:0] b, input int hold, input int gap);
        int a;
        i_byte    = b;
        i_byte_en = 1'b1;
        a = cyc + 2;
        model(b, a);
        if (pend.size() != 0 && hold + gap > TO) push_err(a + TO);
        repeat (hold) @(negedge clk);
        i_byte_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_key_valid && o_err) begin
            total++;
            bad++;
            $display("FAIL both_pulses t=%0d valid=1 err=1 required mutually exclusive", cyc);
        end else if (o_key_valid || o_err) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event t=%0d valid=%0b err=%0b code=%h ext=%0b brk=%0b required none",
                         cyc, o_key_valid, o_err, o_key_code, o_key_ext, o_key_break);
            end else begin
                e = q.pop_front();
                if (o_err != e.err || cyc != e.t || o_mods != e.mods ||
                    (!e.err && (o_key_code != e.code || o_key_ext != e.ext || o_key_break != e.brk))) begin
                    bad++;
                    $display("FAIL event got err=%0b t=%0d code=%h ext=%0b brk=%0b mods=%b required err=%0b t=%0d code=%h ext=%0b brk=%0b mods=%b",
                             o_err, cyc, o_key_code, o_key_ext, o_key_break, o_mods,
                             e.err, e.t, e.code, e.ext, e.brk, e.mods);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        total++;
        if ({o_key_valid, o_key_code, o_key_ext, o_key_break, o_err, o_mods} != '0) begin
            bad++;
            $display("FAIL %s got valid=%0b code=%h ext=%0b brk=%0b err=%0b mods=%b required all 0",
                     name, o_key_valid, o_key_code, o_key_ext, o_key_break, o_err, o_mods);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h1C, 4, 3);
        send(8'hE0, 1, 2);
        send(8'hF0, 2, 2);
        send(8'h75, 1, 3);
        send(8'hF0, 1, 2);
        send(8'hE0, 1, 2);
        send(8'h1C, 1, 2);
        send(8'hFF, 3, 2);
        send(8'h00, 1, 2);
        send(8'hE0, 1, 29);
        send(8'h74, 2, 3);
        send(8'hE0, 1, 19);
        send(8'h75, 1, 3);
        send(8'hE0, 1, 20);
        send(8'h75, 1, 3);
        send(8'hE1, 1, 2);
        send(8'hAA, 1, 2);
        send(8'h12, 1, 2);
        send(8'hE0, 1, 2);
        send(8'h14, 1, 2);
        send(8'hF0, 1, 2);
        send(8'h12, 1, 2);
        send(8'hE0, 1, 2);
        send(8'h12, 1, 2);
        send(8'h11, 1, 2);
        send(8'h59, 1, 3);
        send(8'hF0, 1, 2);
        #2 i_rst_n = 1'b0;
        #1 check_zero("async_reset");
        pend.delete();
        mods = 3'b000;
        @(negedge clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h1C, 2, 3);
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            case (r)
                0, 1, 2:  b = 8'hE0;
                3, 4, 5:  b = 8'hF0;
                6:        b = $urandom_range(0, 1) != 0 ? 8'hFF : 8'h00;
                7:        b = 8'h12;
                8:        b = 8'h59;
                9:        b = 8'h14;
                10:       b = 8'h11;
                default:  b = 8'($urandom_range(1, 254));
            endcase
            send(b, $urandom_range(1, 4),
                 $urandom_range(0, 9) == 0 ? $urandom_range(30, 40) : $urandom_range(1, 8));
        end
        repeat (TO + 10) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got pending=%0d required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
